hub75_rx: RTL and testbench
===========================

HUB75_RX -- requirements
Module: hub75_rx

Interface
REQ-001 Parameter COLS, default 64: pixels shifted per scan row.
REQ-002 Parameter ROWS, default 16: scan-row addresses; displayed lines = 2*ROWS.
REQ-003 clk  input  1  single clock; all inputs are sampled on its rising edge (same domain as the panel driver).
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 A, B, C, D  input  1 each  scan-row address, {D,C,B,A}.
REQ-006 R0, G0, B0  input  1 each  upper-half pixel colour.
REQ-007 R1, G1, B1  input  1 each  lower-half pixel colour.
REQ-008 OE  input  1  shift qualifier; a shift occurs when OE=1 and LAT=0.
REQ-009 LAT  input  1  latch strobe; a rising edge commits the row.
REQ-010 rd_addr  input  11  frame-buffer read address, {line[4:0], col[5:0]}.
REQ-011 rd_rgb  output  3  {R,G,B} at rd_addr, one-cycle latency.
REQ-012 row_done  output  1  one-cycle pulse when a row is committed.
REQ-013 row_idx  output  4  scan-row address of the last committed row.
REQ-014 frame_done  output  1  one-cycle pulse when scan row ROWS-1 is committed.
REQ-015 err_len  output  1  sticky: a LAT edge arrived with a shift count other than COLS.
REQ-016 err_ovr  output  1  sticky: more than COLS shifts arrived before a LAT edge.
REQ-017 err_clr  input  1  synchronous clear of err_len and err_ovr.

Function
REQ-018 The state machine SHALL have three states: IDLE, SHIFT and COMMIT.
REQ-019 IDLE->SHIFT on the first shift cycle; SHIFT->COMMIT on a LAT rising edge; COMMIT->IDLE after exactly COMMIT_CYC = COLS cycles.
REQ-020 On each shift cycle the block SHALL store the 6-bit {R0,G0,B0,R1,G1,B1} at position shift_cnt in a COLS x 6 line register, then increment shift_cnt.
REQ-021 shift_cnt SHALL be 7 bits wide and saturate at COLS; a shift while shift_cnt==COLS SHALL set err_ovr and discard the sample.
REQ-022 {D,C,B,A} SHALL be captured on the LAT rising edge (LAT=1, previous LAT=0) as the commit row r.
REQ-023 If shift_cnt==COLS and err_ovr was not raised in this row, COMMIT SHALL write line r, col k <- upper[k] and line r+ROWS, col k <- lower[k] for k=0..COLS-1, at two frame-buffer writes per cycle.
REQ-024 Otherwise the row SHALL be discarded: COMMIT is skipped, err_len (or err_ovr) is set, and no frame-buffer write occurs.
REQ-025 shift_cnt SHALL return to 0 on every LAT rising edge, whether or not the row commits.
REQ-026 Shifts arriving during COMMIT SHALL fill a second line register (ping-pong); a LAT edge arriving while COMMIT is still busy SHALL set err_ovr and drop that row.
REQ-027 row_done and row_idx<=r SHALL assert in the cycle after the last COMMIT write; frame_done SHALL assert in the same cycle when r==ROWS-1.
REQ-028 LAT held high for several cycles SHALL count as one edge; OE=1 with LAT=1 SHALL not shift.
REQ-029 A read and a write to the same address in the same cycle SHALL return the old data (read-before-write).
REQ-030 err_clr in the same cycle as an error event SHALL leave the flag set.

Reset
REQ-031 While rst_n=0: state=IDLE, shift_cnt=0, ping-pong select=0, row_idx=0, rd_rgb=0, and row_done, frame_done, err_len and err_ovr=0.
REQ-032 Frame-buffer contents SHALL not be reset; reset mid-COMMIT abandons the row, and partially written lines are permitted.

Structure
REQ-033 A shared package hub75_pkg SHALL hold COLS, ROWS, the state encoding and the pixel field order {R0,G0,B0,R1,G1,B1}.
REQ-034 The frame buffer SHALL be a sub-module hub75_rx_fb: a 2*ROWS*COLS x 3-bit RAM with two write ports and one registered read port, suitable for block RAM.

Verification
REQ-035 64 shifts with pixel k upper=3'b100, lower=3'b001, rows {D..A}=5, then a LAT pulse -> row_done and row_idx=5 after 65 cycles; rd_addr {5,k} reads 3'b100 and {21,k} reads 3'b001.
REQ-036 63 shifts then LAT -> err_len=1, no row_done, and the frame buffer is unchanged.
REQ-037 65 shifts then LAT -> err_ovr=1, the row is dropped; err_clr -> both flags 0 the next cycle.
REQ-038 16 back-to-back rows 0..15, with LAT held 3 cycles each -> 16 row_done pulses and one frame_done, coincident with row 15.
REQ-039 rst_n dropped in the 10th COMMIT cycle -> all outputs 0 immediately; a new 64-shift row after release commits correctly.
REQ-040 Reading address {5,0} while COMMIT writes it -> rd_rgb returns the old value, and the new value on the next read.

Source files
------------

// File: rtl/hub75_pkg.sv
// Shared HUB75 receiver definitions: panel geometry, controller states and the
// order of the six colour bits captured on each shift.
package hub75_pkg;

  localparam int COLS  = 64;
  localparam int ROWS  = 16;
  localparam int RGB_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  // One shifted sample, {R0,G0,B0,R1,G1,B1}: upper-half colour in the MSBs.
  typedef struct packed {
    logic [RGB_W-1:0] upper;
    logic [RGB_W-1:0] lower;
  } pix_t;

endpackage

// File: rtl/hub75_rx_fb.sv
// Frame buffer: 3-bit pixels, two write ports used by the row commit and a
// registered read port with read-before-write behaviour.
module hub75_rx_fb
#(
  parameter int DEPTH = 2048,
  parameter int AW    = 11
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      we,
  input  logic [AW-1:0]             wa0,
  input  logic [hub75_pkg::RGB_W-1:0] wd0,
  input  logic [AW-1:0]             wa1,
  input  logic [hub75_pkg::RGB_W-1:0] wd1,
  input  logic [AW-1:0]             ra,
  output logic [hub75_pkg::RGB_W-1:0] rd
);
  import hub75_pkg::*;

  logic [RGB_W-1:0] mem [DEPTH];
  logic [RGB_W-1:0] rd_q, rd_d;

  // The commit always targets two different lines, so the ports never collide.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wa0] <= wd0;
      mem[wa1] <= wd1;
    end
  end

  always_comb rd_d = mem[ra];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_q <= '0;
    else        rd_q <= rd_d;
  end

  assign rd = rd_q;

endmodule

// File: rtl/hub75_rx.sv
// HUB75 panel snooper: captures shifted rows into ping-pong line registers and
// copies each complete row into a frame buffer on the latch strobe.
module hub75_rx
#(
  parameter int COLS = hub75_pkg::COLS,
  parameter int ROWS = hub75_pkg::ROWS,
  localparam int COL_W  = $clog2(COLS),
  localparam int LINE_W = $clog2(2 * ROWS),
  localparam int AW     = LINE_W + COL_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          A,
  input  logic          B,
  input  logic          C,
  input  logic          D,
  input  logic          R0,
  input  logic          G0,
  input  logic          B0,
  input  logic          R1,
  input  logic          G1,
  input  logic          B1,
  input  logic          OE,
  input  logic          LAT,
  input  logic [AW-1:0] rd_addr,
  output logic [2:0]    rd_rgb,
  output logic          row_done,
  output logic [3:0]    row_idx,
  output logic          frame_done,
  output logic          err_len,
  output logic          err_ovr,
  input  logic          err_clr
);
  import hub75_pkg::*;

  localparam logic [6:0]       CNT_FULL = 7'(COLS);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

  state_e                state_q, state_d;
  logic [6:0]            shift_cnt_q, shift_cnt_d;
  logic                  ovr_row_q, ovr_row_d;
  logic                  sel_q, sel_d;
  logic                  lat_q, lat_d;
  pix_t [1:0][COLS-1:0]  line_q, line_d;
  logic [3:0]            row_r_q, row_r_d;
  logic [COL_W-1:0]      ccnt_q, ccnt_d;
  logic                  row_done_q, row_done_d;
  logic                  frame_done_q, frame_done_d;
  logic [3:0]            row_idx_q, row_idx_d;
  logic                  err_len_q, err_len_d;
  logic                  err_ovr_q, err_ovr_d;

  logic                  shift, lat_rise, busy, commit_ok, go_commit;
  logic                  fb_we, commit_last, len_evt, ovr_evt;
  logic [LINE_W-1:0]     line_up, line_lo;
  logic [AW-1:0]         wa_up, wa_lo;
  pix_t                  cpix;

  assign shift     = OE & ~LAT;
  assign lat_rise  = LAT & ~lat_q;
  assign busy      = (state_q == ST_COMMIT);
  assign commit_ok = (shift_cnt_q == CNT_FULL) && !ovr_row_q;
  assign go_commit = lat_rise && !busy && commit_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (go_commit) state_d = ST_COMMIT;
                 else if (shift) state_d = ST_SHIFT;
      ST_SHIFT:  if (lat_rise) state_d = go_commit ? ST_COMMIT : ST_IDLE;
      ST_COMMIT: if (ccnt_q == COL_LAST) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    fb_we       = 1'b0;
    commit_last = 1'b0;
    if (state_q == ST_COMMIT) begin
      fb_we       = 1'b1;
      commit_last = (ccnt_q == COL_LAST);
    end
  end

  // Shift capture and latch handling. The committing row lives in line[~sel]
  // so new shifts can fill line[sel] while the commit drains.
  always_comb begin
    shift_cnt_d = shift_cnt_q;
    ovr_row_d   = ovr_row_q;
    sel_d       = sel_q;
    line_d      = line_q;
    row_r_d     = row_r_q;
    lat_d       = LAT;
    len_evt     = 1'b0;
    ovr_evt     = 1'b0;
    if (shift) begin
      if (shift_cnt_q == CNT_FULL) begin
        ovr_evt   = 1'b1;
        ovr_row_d = 1'b1;
      end else begin
        line_d[sel_q][shift_cnt_q[COL_W-1:0]] = pix_t'({R0, G0, B0, R1, G1, B1});
        shift_cnt_d = shift_cnt_q + 7'd1;
      end
    end
    if (lat_rise) begin
      shift_cnt_d = '0;
      ovr_row_d   = 1'b0;
      if (busy || ovr_row_q) ovr_evt = 1'b1;
      else if (!commit_ok)   len_evt = 1'b1;
      else begin
        row_r_d = {D, C, B, A};
        sel_d   = ~sel_q;
      end
    end
  end

  always_comb begin
    ccnt_d       = (busy && !commit_last) ? ccnt_q + 1'b1 : '0;
    row_done_d   = commit_last;
    frame_done_d = commit_last && (row_r_q == 4'(ROWS - 1));
    row_idx_d    = commit_last ? row_r_q : row_idx_q;
    err_len_d    = (err_len_q & ~err_clr) | len_evt;
    err_ovr_d    = (err_ovr_q & ~err_clr) | ovr_evt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_cnt_q  <= '0;
      ovr_row_q    <= 1'b0;
      sel_q        <= 1'b0;
      lat_q        <= 1'b0;
      row_r_q      <= '0;
      ccnt_q       <= '0;
      row_done_q   <= 1'b0;
      frame_done_q <= 1'b0;
      row_idx_q    <= '0;
      err_len_q    <= 1'b0;
      err_ovr_q    <= 1'b0;
    end else begin
      shift_cnt_q  <= shift_cnt_d;
      ovr_row_q    <= ovr_row_d;
      sel_q        <= sel_d;
      lat_q        <= lat_d;
      row_r_q      <= row_r_d;
      ccnt_q       <= ccnt_d;
      row_done_q   <= row_done_d;
      frame_done_q <= frame_done_d;
      row_idx_q    <= row_idx_d;
      err_len_q    <= err_len_d;
      err_ovr_q    <= err_ovr_d;
    end
  end

  // Line contents are only meaningful once a full row has been shifted.
  always_ff @(posedge clk) line_q <= line_d;

  assign cpix    = line_q[~sel_q][ccnt_q];
  assign line_up = LINE_W'(row_r_q);
  assign line_lo = LINE_W'(row_r_q) + LINE_W'(ROWS);
  assign wa_up   = {line_up, ccnt_q};
  assign wa_lo   = {line_lo, ccnt_q};

  hub75_rx_fb #(
    .DEPTH (2 * ROWS * COLS),
    .AW    (AW)
  ) u_fb (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (fb_we),
    .wa0   (wa_up),
    .wd0   (cpix.upper),
    .wa1   (wa_lo),
    .wd1   (cpix.lower),
    .ra    (rd_addr),
    .rd    (rd_rgb)
  );

  assign row_done   = row_done_q;
  assign row_idx    = row_idx_q;
  assign frame_done = frame_done_q;
  assign err_len    = err_len_q;
  assign err_ovr    = err_ovr_q;

endmodule

// File: tb/tb_hub75_rx.sv
// Bench for hub75_rx: directed rows plus randomized traffic, every output
// checked each cycle against a row-level model of the receiver.
module tb_hub75_rx;
  localparam int COLS = 64;
  localparam int ROWS = 16;
  localparam int FBN  = 2 * ROWS * COLS;

  logic clk = 1'b0, rst_n = 1'b0;
  logic A = 0, B = 0, C = 0, D = 0;
  logic R0 = 0, G0 = 0, B0 = 0, R1 = 0, G1 = 0, B1 = 0;
  logic OE = 0, LAT = 0, err_clr = 0;
  logic [10:0] rd_addr = '0;
  logic [2:0]  rd_rgb;
  logic        row_done, frame_done, err_len, err_ovr;
  logic [3:0]  row_idx;

  hub75_rx dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .C(C), .D(D),
    .R0(R0), .G0(G0), .B0(B0), .R1(R1), .G1(G1), .B1(B1),
    .OE(OE), .LAT(LAT), .rd_addr(rd_addr), .rd_rgb(rd_rgb),
    .row_done(row_done), .row_idx(row_idx), .frame_done(frame_done),
    .err_len(err_len), .err_ovr(err_ovr), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  bit rnd_mode = 0;
  int done_cnt = 0, frame_cnt = 0, frame_ok_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (row level) ----------------
  logic [5:0] q[$], c_pix[$];
  bit         ovr_row = 0, lat_prev = 0, c_act = 0;
  int         c_k = 0, c_row = 0;
  logic [2:0] fbm [FBN];
  bit         known [FBN];
  bit         e_row_done = 0, e_frame_done = 0, e_err_len = 0, e_err_ovr = 0, e_rd_known = 1;
  logic [3:0] e_row_idx = 0;
  logic [2:0] e_rd = 0;
  bit         m_busy, m_len, m_ovr;

  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete(); ovr_row = 0; lat_prev = 0; c_act = 0; c_k = 0;
      e_row_done = 0; e_frame_done = 0; e_row_idx = 0;
      e_err_len = 0; e_err_ovr = 0; e_rd = 0; e_rd_known = 1;
    end else begin
      e_rd = fbm[rd_addr]; e_rd_known = known[rd_addr];
      e_row_done = 0; e_frame_done = 0; m_len = 0; m_ovr = 0;
      m_busy = c_act;
      if (c_act) begin
        fbm[c_row * COLS + c_k] = c_pix[c_k][5:3];
        known[c_row * COLS + c_k] = 1;
        fbm[(c_row + ROWS) * COLS + c_k] = c_pix[c_k][2:0];
        known[(c_row + ROWS) * COLS + c_k] = 1;
        if (c_k == COLS - 1) begin
          c_act = 0; e_row_done = 1; e_row_idx = 4'(c_row);
          e_frame_done = (c_row == ROWS - 1);
        end
        c_k++;
      end
      if (OE && !LAT) begin
        if (q.size() < COLS) q.push_back({R0, G0, B0, R1, G1, B1});
        else begin ovr_row = 1; m_ovr = 1; end
      end
      if (LAT && !lat_prev) begin
        if (m_busy || ovr_row) m_ovr = 1;
        else if (q.size() != COLS) m_len = 1;
        else begin c_act = 1; c_k = 0; c_row = {D, C, B, A}; c_pix = q; end
        q.delete(); ovr_row = 0;
      end
      lat_prev = LAT;
      e_err_len = (e_err_len && !err_clr) || m_len;
      e_err_ovr = (e_err_ovr && !err_clr) || m_ovr;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_row_done", row_done, 0);   chk("rst_frame_done", frame_done, 0);
      chk("rst_row_idx", row_idx, 0);     chk("rst_err_len", err_len, 0);
      chk("rst_err_ovr", err_ovr, 0);     chk("rst_rd_rgb", rd_rgb, 0);
    end else begin
      chk("row_done", row_done, e_row_done);   chk("frame_done", frame_done, e_frame_done);
      chk("row_idx", row_idx, e_row_idx);      chk("err_len", err_len, e_err_len);
      chk("err_ovr", err_ovr, e_err_ovr);
      if (e_rd_known) chk("rd_rgb", rd_rgb, e_rd);
      if (row_done) done_cnt++;
      if (frame_done) frame_cnt++;
      if (frame_done && row_done && row_idx == 4'd15) frame_ok_cnt++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk); #1;
    if (rnd_mode) begin
      rd_addr = 11'($urandom);
      err_clr = ($urandom_range(0, 15) == 0);
    end
  endtask

  task automatic shift_px(input logic [5:0] p);
    OE = 1; LAT = 0; {R0, G0, B0, R1, G1, B1} = p;
    step();
    OE = 0;
  endtask

  task automatic shift_rand(input int n);
    for (int i = 0; i < n; i++) shift_px(6'($urandom));
  endtask

  task automatic latch(input logic [3:0] row, input int hold);
    {D, C, B, A} = row; LAT = 1;
    for (int i = 0; i < hold; i++) begin
      OE = rnd_mode ? 1'($urandom) : 1'b0;
      step();
    end
    LAT = 0; OE = 0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    for (int i = 1; i <= 200; i++) begin
      step();
      if (row_done) begin cyc = i; break; end
    end
  endtask

  logic [5:0] ref_row [COLS];
  int cyc, d0, f0, fo0;

  initial begin
    for (int i = 0; i < FBN; i++) begin known[i] = 0; fbm[i] = 0; end
    repeat (3) step();
    rst_n = 1;
    step();

    // Row 5: upper red, lower blue.
    for (int k = 0; k < COLS; k++) shift_px(6'b100_001);
    latch(4'd5, 1);
    wait_done(cyc);
    chk("lat_to_done_cycles", cyc + 1, 65);
    chk("row_idx_5", row_idx, 5);
    for (int k = 0; k < COLS; k += 21) begin
      rd_addr = 11'(5 * COLS + k);  step(); chk("fb_upper_row5", rd_rgb, 3'b100);
      rd_addr = 11'(21 * COLS + k); step(); chk("fb_lower_row21", rd_rgb, 3'b001);
    end

    // Short row must not disturb row 3.
    for (int k = 0; k < COLS; k++) begin ref_row[k] = 6'($urandom); shift_px(ref_row[k]); end
    latch(4'd3, 1);
    repeat (70) step();
    shift_rand(63);
    latch(4'd3, 1);
    chk("err_len_63", err_len, 1);
    d0 = done_cnt;
    repeat (70) step();
    chk("no_done_63", done_cnt - d0, 0);
    for (int k = 0; k < COLS; k += 31) begin
      rd_addr = 11'(3 * COLS + k); step(); chk("row3_unchanged", rd_rgb, {29'b0, ref_row[k][5:3]});
    end
    err_clr = 1; step(); err_clr = 0;

    // Overrun row and flag clear.
    shift_rand(65);
    latch(4'd9, 1);
    chk("err_ovr_65", err_ovr, 1);
    chk("err_len_65", err_len, 0);
    err_clr = 1; step(); err_clr = 0;
    chk("clr_err_ovr", err_ovr, 0);
    chk("clr_err_len", err_len, 0);

    // Clear colliding with a new length error keeps the flag.
    shift_rand(10);
    err_clr = 1;
    latch(4'd1, 1);
    err_clr = 0;
    chk("clr_vs_event", err_len, 1);
    err_clr = 1; step(); err_clr = 0;

    // Read-before-write on {5,0} while row 5 is rewritten.
    for (int k = 0; k < COLS; k++) shift_px(6'b011_010);
    rd_addr = 11'(5 * COLS);
    latch(4'd5, 1);
    step();
    chk("rbw_old", rd_rgb, 3'b100);
    step();
    chk("rbw_new", rd_rgb, 3'b011);
    repeat (70) step();

    // A full frame, back to back, LAT held 3 cycles.
    d0 = done_cnt; f0 = frame_cnt; fo0 = frame_ok_cnt;
    for (int r = 0; r < ROWS; r++) begin
      shift_rand(COLS);
      latch(4'(r), 3);
    end
    repeat (80) step();
    chk("frame_rows", done_cnt - d0, 16);
    chk("frame_done_cnt", frame_cnt - f0, 1);
    chk("frame_done_row15", frame_ok_cnt - fo0, 1);

    // Reset in the 10th commit cycle.
    shift_rand(COLS);
    rd_addr = 11'(5 * COLS);
    latch(4'd2, 1);
    repeat (9) step();
    rst_n = 0;
    #1;
    chk("async_row_idx", row_idx, 0);
    chk("async_rd_rgb", rd_rgb, 0);
    chk("async_err", {err_len, err_ovr, row_done, frame_done}, 0);
    repeat (2) step();
    rst_n = 1;
    step();
    for (int k = 0; k < COLS; k++) begin ref_row[k] = 6'($urandom); shift_px(ref_row[k]); end
    latch(4'd7, 1);
    wait_done(cyc);
    chk("post_rst_done", cyc, 64);
    chk("post_rst_idx", row_idx, 7);
    for (int k = 0; k < COLS; k += 9) begin
      rd_addr = 11'(7 * COLS + k);  step(); chk("post_rst_up", rd_rgb, {29'b0, ref_row[k][5:3]});
      rd_addr = 11'(23 * COLS + k); step(); chk("post_rst_lo", rd_rgb, {29'b0, ref_row[k][2:0]});
    end

    // Randomized traffic: mostly good rows, some short/long, busy collisions.
    rnd_mode = 1;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 7))
        4:       shift_rand(COLS - 1);
        5:       shift_rand(COLS + 1);
        6:       shift_rand(COLS + 2);
        7:       shift_rand(3);
        default: shift_rand(COLS);
      endcase
      latch(4'($urandom), $urandom_range(1, 3));
      repeat ($urandom_range(0, 2)) step();
    end
    rnd_mode = 0;
    err_clr = 0;
    repeat (80) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #900000;
    n_err++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1);
  end

endmodule
